modbus_rtu_rx_frame_ctrl: RTL and testbench

Receive-side frame controller for the Modbus RTU slave. It sits between the UART byte receiver and the CRC/PDU parser. It delimits frames using the RTU character-gap rules: a gap above 1.5T inside a frame is an error, and silence of 3.5T or more ends the frame. Accepted bytes go into an internal frame buffer, and each complete frame is handed to the parser under a valid/ack handshake.

---
 rtl/modbus_rtu_pkg.sv | 14 +
 rtl/modbus_gap_timer.sv | 19 +
 rtl/modbus_rtu_rx_frame_ctrl.sv | 113 +++++++++++
 tb/tb_modbus_rtu_rx_frame_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/modbus_rtu_pkg.sv
// modbus_rtu_pkg: shared states, error codes and gap-threshold helper for the RTU receiver
package modbus_rtu_pkg;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV, HOLD} state_t;
  localparam logic [1:0] ERR_GAP   = 2'b01;
  localparam logic [1:0] ERR_OVR   = 2'b10;
  localparam logic [1:0] ERR_SHORT = 2'b11;
  // Above 19200 baud the gaps are fixed at 750us / 1750us instead of scaling with the bit time
  function automatic int gap_ticks(input int clk_freq, input int baud, input bit long_gap);
    int bps;
    bps = clk_freq / baud;
    return baud <= 19200 ? (long_gap ? 35 : 15) * bps / 10
                         : clk_freq / 1000000 * (long_gap ? 1750 : 750);
  endfunction
endpackage

// File: rtl/modbus_gap_timer.sv
// modbus_gap_timer: line-silence counter saturating at T35 with 1.5T / 3.5T flags
module modbus_gap_timer #(
  parameter int T15 = 15,
  parameter int T35 = 35
)(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_t15,
  output logic o_t35
);
  localparam int W = $clog2(T35 + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (r_cnt != W'(T35)) r_cnt <= r_cnt + 1'b1;
  assign o_t15 = r_cnt > W'(T15);
  assign o_t35 = r_cnt == W'(T35);
endmodule

// File: rtl/modbus_rtu_rx_frame_ctrl.sv
// modbus_rtu_rx_frame_ctrl: RTU frame delimiting by character gaps, frame buffer and parser handshake
module modbus_rtu_rx_frame_ctrl
  import modbus_rtu_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int MAX_LEN   = 256,
  parameter int MIN_LEN   = 4
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_done,
  input  logic                         rx_state,
  output logic                         frame_valid,
  output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
  input  logic                         frame_ack,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
  output logic [7:0]                   rd_data,
  output logic                         frame_err,
  output logic [1:0]                   err_code,
  output logic                         busy
);
  localparam int LW  = $clog2(MAX_LEN + 1);
  localparam int AW  = $clog2(MAX_LEN);
  localparam int T15 = gap_ticks(CLK_FREQ, BAUD_RATE, 1'b0);
  localparam int T35 = gap_ticks(CLK_FREQ, BAUD_RATE, 1'b1);
  state_t        r_state, w_next;
  logic [LW-1:0] r_len, w_len, r_frame_len, w_frame_len;
  logic          r_valid, w_valid, r_err, w_err, w_we, w_t15, w_t35;
  logic [1:0]    r_code, w_code;
  logic [AW-1:0] w_waddr;
  logic [7:0]    r_mem [MAX_LEN];
  logic [7:0]    r_rd_data;
  modbus_gap_timer #(.T15(T15), .T35(T35)) u_gap (
    .clk   (clk),
    .rst   (rst),
    .i_clr (rx_done || rx_state),
    .o_t15 (w_t15),
    .o_t35 (w_t35)
  );
  // Frame end (t35) is checked before rx_done so a byte landing on the 3.5T boundary is dropped
  always_comb begin
    w_next      = r_state;
    w_len       = r_len;
    w_frame_len = r_frame_len;
    w_valid     = r_valid;
    w_err       = 1'b0;
    w_code      = r_code;
    w_we        = 1'b0;
    w_waddr     = AW'(r_len);
    case (r_state)
      WAIT_IDLE: if (w_t35) w_next = IDLE;
      IDLE: if (rx_done) begin
        w_we    = 1'b1;
        w_waddr = '0;
        w_len   = LW'(1);
        w_next  = RECV;
      end
      RECV: if (w_t35) begin
        if (r_len >= LW'(MIN_LEN)) begin
          w_frame_len = r_len;
          w_valid     = 1'b1;
          w_next      = HOLD;
        end else begin
          w_err  = 1'b1;
          w_code = ERR_SHORT;
          w_next = IDLE;
        end
      end else if (rx_done) begin
        if (w_t15 || r_len == LW'(MAX_LEN)) begin
          w_err  = 1'b1;
          w_code = w_t15 ? ERR_GAP : ERR_OVR;
          w_next = WAIT_IDLE;
        end else begin
          w_we  = 1'b1;
          w_len = r_len + 1'b1;
        end
      end
      HOLD: if (frame_ack) begin
        w_valid = 1'b0;
        w_next  = WAIT_IDLE;
      end
      default: w_next = WAIT_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= WAIT_IDLE;
      r_len       <= '0;
      r_frame_len <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= 2'b00;
    end else begin
      r_state     <= w_next;
      r_len       <= w_len;
      r_frame_len <= w_frame_len;
      r_valid     <= w_valid;
      r_err       <= w_err;
      r_code      <= w_code;
    end
  always_ff @(posedge clk)
    if (w_we) r_mem[w_waddr] <= rx_data;
  always_ff @(posedge clk)
    r_rd_data <= rst ? 8'h00 : r_mem[rd_addr];
  assign frame_valid = r_valid;
  assign frame_len   = r_frame_len;
  assign frame_err   = r_err;
  assign err_code    = r_code;
  assign rd_data     = r_rd_data;
  assign busy        = r_state == RECV;
endmodule

// File: tb/tb_modbus_rtu_rx_frame_ctrl.sv
// tb_modbus_rtu_rx_frame_ctrl: directed scoreboard bench for the RTU receive frame controller
module tb_modbus_rtu_rx_frame_ctrl;
  // 100 kHz / 10 kBd stays on the bit-time formula path: BPS=10, T15=15, T35=35
  logic       clk = 1'b0, rst = 1'b1, rx_done = 1'b0, rx_state = 1'b0, frame_ack = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [2:0] rd_addr = 3'd0;
  logic       frame_valid, frame_err, busy;
  logic [3:0] frame_len;
  logic [1:0] err_code;
  logic [7:0] rd_data;
  int         n_vec = 0, n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] seq [$];
  always #5 clk = ~clk;
  modbus_rtu_rx_frame_ctrl #(
    .CLK_FREQ(100000), .BAUD_RATE(10000), .MAX_LEN(8), .MIN_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_state(rx_state),
    .frame_valid(frame_valid), .frame_len(frame_len), .frame_ack(frame_ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_err(frame_err), .err_code(err_code),
    .busy(busy)
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit push);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    if (push) exp_q.push_back(b);
  endtask
  task automatic send_seq(input int gap, input bit push);
    foreach (seq[i]) begin
      if (i != 0) tick(gap - 1);
      send(seq[i], push);
    end
  endtask
  task automatic read_frame(input int n);
    for (int i = 0; i < n; i++) begin
      rd_addr = 3'(i);
      tick(1);
      check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(exp_q.pop_front()));
    end
  endtask
  initial begin
    tick(2);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_len", 32'(frame_len), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(5);
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_seq(10, 1'b0);
    check("gate_busy", 32'(busy), 32'd0);
    tick(35);
    check("gate_valid", 32'(frame_valid), 32'd0);
    tick(5);
    seq = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
    send_seq(10, 1'b1);
    check("norm_busy", 32'(busy), 32'd1);
    tick(35);
    check("norm_valid_early", 32'(frame_valid), 32'd0);
    tick(1);
    check("norm_valid", 32'(frame_valid), 32'd1);
    check("norm_len", 32'(frame_len), 32'd8);
    send(8'hEE, 1'b0);
    check("hold_len", 32'(frame_len), 32'd8);
    check("hold_err", 32'(frame_err), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    read_frame(8);
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    check("ack_valid", 32'(frame_valid), 32'd0);
    tick(40);
    seq = '{8'h01, 8'h03};
    send_seq(10, 1'b1);
    tick(19);
    send(8'h20, 1'b0);
    check("gap_err", 32'(frame_err), 32'd1);
    check("gap_code", 32'(err_code), 32'(2'b01));
    tick(1);
    check("gap_err_pulse", 32'(frame_err), 32'd0);
    exp_q.delete();
    seq = '{8'h05, 8'h06, 8'h07, 8'h08};
    send_seq(10, 1'b0);
    tick(40);
    check("gap_relock_valid", 32'(frame_valid), 32'd0);
    check("gap_relock_busy", 32'(busy), 32'd0);
    seq = '{8'hA1, 8'hA2, 8'hA3};
    send_seq(10, 1'b0);
    tick(35);
    check("short_err_early", 32'(frame_err), 32'd0);
    tick(1);
    check("short_err", 32'(frame_err), 32'd1);
    check("short_code", 32'(err_code), 32'(2'b11));
    check("short_valid", 32'(frame_valid), 32'd0);
    seq = '{8'h0B, 8'h10, 8'hB0, 8'h0D};
    send_seq(10, 1'b1);
    tick(35);
    check("after_short_valid_early", 32'(frame_valid), 32'd0);
    tick(1);
    check("after_short_valid", 32'(frame_valid), 32'd1);
    check("after_short_len", 32'(frame_len), 32'd4);
    read_frame(4);
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    tick(40);
    seq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
    send_seq(10, 1'b0);
    check("ovr_err", 32'(frame_err), 32'd1);
    check("ovr_code", 32'(err_code), 32'(2'b10));
    tick(1);
    check("ovr_err_pulse", 32'(frame_err), 32'd0);
    tick(40);
    seq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    send_seq(10, 1'b1);
    tick(35);
    send(8'h77, 1'b0);
    check("edge_valid", 32'(frame_valid), 32'd1);
    check("edge_len", 32'(frame_len), 32'd5);
    check("edge_err", 32'(frame_err), 32'd0);
    read_frame(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_hold_valid", 32'(frame_valid), 32'd0);
    check("rst_hold_len", 32'(frame_len), 32'd0);
    check("rst_hold_rd_data", 32'(rd_data), 32'd0);
    tick(40);
    seq = '{8'h5A, 8'h5B};
    send_seq(10, 1'b0);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_code", 32'(err_code), 32'd0);
    check("mid_rst_err", 32'(frame_err), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    send(8'h99, 1'b0);
    check("mid_rst_gate_busy", 32'(busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
